// File: rtl/mmio_uart_bridge.sv
// Memory-map controller: decodes core data-bus accesses to RAM, GPIO and
// NUM_CH UART channels, each with an RX FIFO, sticky error flags and a TX launch FSM.
module mmio_uart_bridge #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [31:0] GPIO_OUT_ADDR = 32'h10010024,
  parameter logic [31:0] GPIO_IN_ADDR  = 32'h10010028,
  parameter logic [31:0] UART_BASE     = 32'h10010030
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    re,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   WD,
  input  logic [DATA_WIDTH-1:0]   ReadRAM,
  input  logic [DATA_WIDTH-1:0]   ReadGPIO,
  input  logic [NUM_CH-1:0]       rx_valid,
  input  logic [8*NUM_CH-1:0]     rx_byte,
  input  logic [NUM_CH-1:0]       rx_parity_err,
  input  logic [NUM_CH-1:0]       tx_busy,
  output logic                    weRAM,
  output logic                    weGPIO,
  output logic [DATA_WIDTH-1:0]   AddrRAM,
  output logic [DATA_WIDTH-1:0]   DataRAM,
  output logic [DATA_WIDTH-1:0]   DataGPIO,
  output logic [NUM_CH-1:0]       tx_start,
  output logic [8*NUM_CH-1:0]     tx_byte,
  output logic                    irq,
  output logic [DATA_WIDTH-1:0]   RD
);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WIN = 16 * NUM_CH;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

  logic [ADDR_WIDTH-1:0] uart_off;
  logic [3:0]            reg_off;
  logic                  hit_gpio_out, hit_gpio_in, hit_uart, hit_ram;
  logic [NUM_CH-1:0]     ch_sel;

  logic [7:0]    fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q [NUM_CH];
  logic [PW-1:0] wr_ptr_q [NUM_CH];
  logic [CW-1:0] count_q  [NUM_CH];
  logic [NUM_CH-1:0] ovr_q, par_q;

  logic [NUM_CH-1:0] not_empty, full, pop, push_ok, stat_rd, txd_ld, launch, tx_active;

  tx_state_t state_q  [NUM_CH];
  tx_state_t state_d  [NUM_CH];
  logic [1:0] wb_cnt_q [NUM_CH];
  logic [1:0] wb_cnt_d [NUM_CH];
  logic [7:0] tx_hold_q [NUM_CH];

  // Address decode in priority order: GPIO out, GPIO in, UART windows, RAM
  always_comb begin
    uart_off     = A - ADDR_WIDTH'(UART_BASE);
    reg_off      = uart_off[3:0];
    hit_gpio_out = (A == ADDR_WIDTH'(GPIO_OUT_ADDR));
    hit_gpio_in  = !hit_gpio_out && (A == ADDR_WIDTH'(GPIO_IN_ADDR));
    hit_uart     = !hit_gpio_out && !hit_gpio_in &&
                   (A >= ADDR_WIDTH'(UART_BASE)) && (uart_off < ADDR_WIDTH'(WIN));
    hit_ram      = !hit_gpio_out && !hit_gpio_in && !hit_uart &&
                   (A[ADDR_WIDTH-1 -: 16] == 16'h1001);
    ch_sel = '0;
    for (int n = 0; n < NUM_CH; n++)
      ch_sel[n] = hit_uart && (uart_off[ADDR_WIDTH-1:4] == (ADDR_WIDTH-4)'(n));
  end

  // Pass-through bus signals and write enables
  always_comb begin
    weGPIO   = we && hit_gpio_out;
    weRAM    = we && hit_ram;
    AddrRAM  = DATA_WIDTH'(A);
    DataRAM  = WD;
    DataGPIO = WD;
  end

  // Per-channel access strobes derived from the current bus cycle
  always_comb begin
    not_empty = '0; full = '0; pop = '0; push_ok = '0;
    stat_rd = '0; txd_ld = '0; launch = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      not_empty[n] = (count_q[n] != '0);
      full[n]      = (count_q[n] == CW'(FIFO_DEPTH));
      pop[n]       = re && ch_sel[n] && (reg_off == 4'h0) && not_empty[n];
      push_ok[n]   = rx_valid[n] && (!full[n] || pop[n]);
      stat_rd[n]   = re && ch_sel[n] && (reg_off == 4'h8);
      txd_ld[n]    = we && ch_sel[n] && (reg_off == 4'h4) && (state_q[n] == S_IDLE);
      launch[n]    = we && ch_sel[n] && (reg_off == 4'hC) && (WD != '0) &&
                     (state_q[n] == S_IDLE);
    end
  end

  // Read data mux; zero whenever re is low or the address is unmapped
  always_comb begin
    RD = '0;
    if (re) begin
      if (hit_gpio_in) RD = ReadGPIO;
      else if (hit_ram) RD = ReadRAM;
      else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_sel[n]) begin
            case (reg_off)
              4'h0:    RD = not_empty[n] ? DATA_WIDTH'(fifo_mem[n][rd_ptr_q[n]]) : '0;
              4'h8:    RD = DATA_WIDTH'({tx_active[n], par_q[n], ovr_q[n], full[n], not_empty[n]});
              4'hC:    RD = DATA_WIDTH'(tx_active[n]);
              default: RD = '0;
            endcase
          end
        end
      end
    end
  end

  // FIFO storage; occupancy is tracked by the pointer/count registers
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++)
      if (push_ok[n]) fifo_mem[n][wr_ptr_q[n]] <= rx_byte[8*n +: 8];
  end

  // FIFO pointers, count and sticky flags; a same-cycle set beats read-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        rd_ptr_q[n] <= '0;
        wr_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
      ovr_q <= '0;
      par_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (push_ok[n]) wr_ptr_q[n] <= wr_ptr_q[n] + PW'(1);
        if (pop[n])     rd_ptr_q[n] <= rd_ptr_q[n] + PW'(1);
        count_q[n] <= count_q[n] + CW'(push_ok[n]) - CW'(pop[n]);
        if (rx_valid[n] && full[n] && !pop[n]) ovr_q[n] <= 1'b1;
        else if (stat_rd[n])                   ovr_q[n] <= 1'b0;
        if (rx_valid[n] && rx_parity_err[n])   par_q[n] <= 1'b1;
        else if (stat_rd[n])                   par_q[n] <= 1'b0;
      end
    end
  end

  // TX FSM state register, timeout counter and holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n]   <= S_IDLE;
        wb_cnt_q[n]  <= '0;
        tx_hold_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        state_q[n]  <= state_d[n];
        wb_cnt_q[n] <= wb_cnt_d[n];
        if (txd_ld[n]) tx_hold_q[n] <= WD[7:0];
      end
    end
  end

  // TX FSM next state; WAIT_BUSY gives up after four cycles without tx_busy
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      state_d[n]  = state_q[n];
      wb_cnt_d[n] = '0;
      case (state_q[n])
        S_IDLE:      if (launch[n]) state_d[n] = S_START;
        S_START:     state_d[n] = S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (tx_busy[n])              state_d[n] = S_WAIT_DONE;
          else if (wb_cnt_q[n] == 2'd3) state_d[n] = S_IDLE;
          else                          wb_cnt_d[n] = wb_cnt_q[n] + 2'd1;
        end
        S_WAIT_DONE: if (!tx_busy[n]) state_d[n] = S_IDLE;
        default:     state_d[n] = S_IDLE;
      endcase
    end
  end

  // TX FSM outputs decoded from the state register
  always_comb begin
    tx_start  = '0;
    tx_active = '0;
    tx_byte   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      tx_start[n]       = (state_q[n] == S_START);
      tx_active[n]      = (state_q[n] != S_IDLE);
      tx_byte[8*n +: 8] = tx_hold_q[n];
    end
  end

  // Interrupt registered from the pending conditions of all channels
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(not_empty | ovr_q | par_q);
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: decode vector table, hand-written
// FIFO/flag/TX sequences and a randomized run against a queue-based model.
module tb_mmio_uart_bridge;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam logic [31:0] UB      = 32'h10010030;
  localparam logic [31:0] RAM_VAL = 32'hDEADBEEF;
  localparam logic [31:0] GPI_VAL = 32'h000000F0;

  logic clk = 1'b0;
  logic rst;
  logic re, we;
  logic [31:0] A, WD, ReadRAM, ReadGPIO;
  logic [NCH-1:0] rx_valid, rx_parity_err, tx_busy;
  logic [8*NCH-1:0] rx_byte;
  logic weRAM, weGPIO;
  logic [31:0] AddrRAM, DataRAM, DataGPIO, RD;
  logic [NCH-1:0] tx_start;
  logic [8*NCH-1:0] tx_byte;
  logic irq;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt [NCH];

  mmio_uart_bridge #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .A(A), .WD(WD),
    .ReadRAM(ReadRAM), .ReadGPIO(ReadGPIO),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_parity_err(rx_parity_err),
    .tx_busy(tx_busy), .weRAM(weRAM), .weGPIO(weGPIO),
    .AddrRAM(AddrRAM), .DataRAM(DataRAM), .DataGPIO(DataGPIO),
    .tx_start(tx_start), .tx_byte(tx_byte), .irq(irq), .RD(RD)
  );

  always #5 clk = ~clk;

  // Count launch pulses per channel, sampled mid-cycle
  always @(negedge clk) begin
    for (int n = 0; n < NCH; n++)
      if (tx_start[n] === 1'b1) start_cnt[n]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    re = 0; we = 0; A = '0; WD = '0;
    rx_valid = '0; rx_byte = '0; rx_parity_err = '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    re = 1; A = addr;
    #2;
    d = RD;
    tick();
    re = 0; A = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    we = 1; A = addr; WD = d;
    tick();
    we = 0; A = '0; WD = '0;
  endtask

  task automatic push(input int ch, input logic [7:0] b, input logic pe);
    rx_valid[ch] = 1'b1; rx_byte[8*ch +: 8] = b; rx_parity_err[ch] = pe;
    tick();
    rx_valid[ch] = 1'b0; rx_byte[8*ch +: 8] = '0; rx_parity_err[ch] = 1'b0;
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        we_ram;
    logic        we_gpio;
  } vec_t;

  vec_t vt [12];

  // Reference model state for the randomized phase
  logic [7:0] mq [NCH][$];
  logic       m_ovr [NCH];
  logic       m_par [NCH];

  function automatic logic [31:0] m_status(input int ch);
    logic [31:0] s;
    s = '0;
    s[0] = (mq[ch].size() != 0);
    s[1] = (mq[ch].size() == DEPTH);
    s[2] = m_ovr[ch];
    s[3] = m_par[ch];
    return s;
  endfunction

  initial begin
    logic [31:0] d;
    logic irq_exp;
    int op, ch;
    logic [31:0] exp_rd;

    for (int n = 0; n < NCH; n++) start_cnt[n] = 0;
    ReadRAM = RAM_VAL; ReadGPIO = GPI_VAL;

    // Reset with every input active
    rst = 1; re = 1; we = 1; A = UB + 32'hC; WD = 32'h1;
    rx_valid = '1; rx_byte = '1; rx_parity_err = '1; tx_busy = '1;
    repeat (3) tick();
    chk("reset_tx_start", 32'(tx_start), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_tx_byte", 32'(tx_byte), 32'h0);
    clr(); tx_busy = '0; rst = 0;
    tick();
    for (int n = 0; n < NCH; n++) begin
      rd(UB + 32'(16*n) + 32'h8, d);
      chk($sformatf("reset_status_ch%0d", n), d, 32'h0);
    end
    chk("reset_irq_after", 32'(irq), 32'h0);

    // Decode table
    vt[0]  = '{1'b0, 1'b1, 32'h10010010, 32'h00001234, 32'h0,    1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'h10010024, 32'h0000005A, 32'h0,    1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h20000000, 32'h0,        32'h0,    1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h10010010, 32'h0,        RAM_VAL,  1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h10010028, 32'h0,        GPI_VAL,  1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h10010028, 32'h0,        32'h0,    1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h20000000, 32'h00000077, 32'h0,    1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h10010028, 32'h00000011, 32'h0,    1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h10010034, 32'h0,        32'h0,    1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'h10010048, 32'h00000003, 32'h0,    1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h10010050, 32'h0,        RAM_VAL,  1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h1001002C, 32'h0,        RAM_VAL,  1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      re = vt[i].re; we = vt[i].we; A = vt[i].a; WD = vt[i].wd;
      #2;
      chk($sformatf("vec%0d_rd", i), RD, vt[i].rd);
      chk($sformatf("vec%0d_weRAM", i), 32'(weRAM), 32'(vt[i].we_ram));
      chk($sformatf("vec%0d_weGPIO", i), 32'(weGPIO), 32'(vt[i].we_gpio));
      chk($sformatf("vec%0d_data", i), DataRAM, vt[i].wd);
      tick();
      clr();
    end

    // Two bytes on ch1, drained in order; ch0 untouched
    push(1, 8'hA5, 1'b0);
    push(1, 8'h3C, 1'b0);
    tick();
    chk("ch1_irq_pending", 32'(irq), 32'h1);
    rd(UB + 32'h10, d); chk("ch1_pop0", d, 32'h000000A5);
    rd(UB + 32'h10, d); chk("ch1_pop1", d, 32'h0000003C);
    rd(UB + 32'h10, d); chk("ch1_pop_empty", d, 32'h0);
    rd(UB + 32'h8, d);  chk("ch0_status_clean", d, 32'h0);
    tick();
    chk("irq_cleared", 32'(irq), 32'h0);

    // Overflow on ch0, then simultaneous push/pop while full
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b0);
    push(0, 8'h44, 1'b0); push(0, 8'h55, 1'b0);
    rd(UB + 32'h8, d); chk("ovf_status", d, 32'h7);
    rd(UB + 32'h8, d); chk("ovf_status_cleared", d, 32'h3);
    rx_valid[0] = 1'b1; rx_byte[7:0] = 8'h66;
    rd(UB, d);
    rx_valid[0] = 1'b0; rx_byte[7:0] = 8'h0;
    chk("full_pushpop_rd", d, 32'h11);
    rd(UB + 32'h8, d); chk("full_pushpop_no_ovr", d, 32'h3);
    rd(UB, d); chk("ovf_pop1", d, 32'h22);
    rd(UB, d); chk("ovf_pop2", d, 32'h33);
    rd(UB, d); chk("ovf_pop3", d, 32'h44);
    rd(UB, d); chk("ovf_pop4", d, 32'h66);
    rd(UB + 32'h8, d); chk("ovf_drained", d, 32'h0);

    // Parity flag: byte still stored; a set beats a same-cycle clear
    push(0, 8'h55, 1'b1);
    rd(UB + 32'h8, d); chk("par_status", d, 32'h9);
    rx_valid[0] = 1'b1; rx_byte[7:0] = 8'h77; rx_parity_err[0] = 1'b1;
    rd(UB + 32'h8, d);
    rx_valid[0] = 1'b0; rx_byte[7:0] = 8'h0; rx_parity_err[0] = 1'b0;
    chk("par_setclr_rd", d, 32'h1);
    rd(UB + 32'h8, d); chk("par_set_wins", d, 32'h9);
    rd(UB + 32'h8, d); chk("par_cleared", d, 32'h1);
    rd(UB, d); chk("par_byte0", d, 32'h55);
    rd(UB, d); chk("par_byte1", d, 32'h77);

    // TX launch with busy handshake on ch0
    wr(UB + 32'h4, 32'h41);
    wr(UB + 32'hC, 32'h1);
    chk("tx_start_pulse", 32'(tx_start), 32'h1);
    chk("tx_byte_ch0", 32'(tx_byte[7:0]), 32'h41);
    tx_busy[0] = 1'b1;
    tick();
    chk("tx_start_one_cycle", 32'(tx_start), 32'h0);
    for (int i = 0; i < 10; i++) begin
      rd(UB + 32'hC, d);
      chk($sformatf("tx_active_busy%0d", i), d, 32'h1);
    end
    wr(UB + 32'hC, 32'h1);
    wr(UB + 32'h4, 32'h99);
    chk("tx_hold_locked", 32'(tx_byte[7:0]), 32'h41);
    chk("tx_no_second_pulse", 32'(start_cnt[0]), 32'h1);
    tx_busy[0] = 1'b0;
    tick();
    rd(UB + 32'hC, d); chk("tx_done_idle", d, 32'h0);

    // TX launch with tx_busy never rising: times out back to IDLE
    wr(UB + 32'hC, 32'h5);
    tick(); tick();
    rd(UB + 32'h8, d); chk("tx_timeout_active", d, 32'h10);
    repeat (4) tick();
    rd(UB + 32'h8, d); chk("tx_timeout_idle", d, 32'h0);
    chk("tx_timeout_pulses", 32'(start_cnt[0]), 32'h2);

    // Reset in the middle of a ch1 transmission
    wr(UB + 32'h1C, 32'h1);
    tx_busy[1] = 1'b1;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0; tx_busy = '0;
    repeat (3) tick();
    chk("rst_mid_tx_pulses", 32'(start_cnt[1]), 32'h1);
    rd(UB + 32'h18, d); chk("rst_mid_tx_status", d, 32'h0);

    // Randomized traffic against the queue model (state is empty after reset)
    for (int n = 0; n < NCH; n++) begin
      mq[n].delete(); m_ovr[n] = 1'b0; m_par[n] = 1'b0;
    end
    irq_exp = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op = int'($urandom_range(2));
      ch = int'($urandom_range(NCH - 1));
      for (int n = 0; n < NCH; n++) begin
        rx_valid[n] = ($urandom_range(99) < 40);
        rx_byte[8*n +: 8] = 8'($urandom);
        rx_parity_err[n] = ($urandom_range(99) < 10);
      end
      re = (op != 0);
      A = UB + 32'(16 * ch) + ((op == 2) ? 32'h8 : 32'h0);
      #2;
      exp_rd = '0;
      if (op == 1 && mq[ch].size() != 0) exp_rd = 32'(mq[ch][0]);
      if (op == 2) exp_rd = m_status(ch);
      chk("rand_rd", RD, exp_rd);
      chk("rand_irq", 32'(irq), 32'(irq_exp));
      irq_exp = 1'b0;
      for (int n = 0; n < NCH; n++)
        if (mq[n].size() != 0 || m_ovr[n] || m_par[n]) irq_exp = 1'b1;
      if (op == 2) begin m_ovr[ch] = 1'b0; m_par[ch] = 1'b0; end
      if (op == 1 && mq[ch].size() != 0) void'(mq[ch].pop_front());
      for (int n = 0; n < NCH; n++) begin
        if (rx_valid[n]) begin
          if (rx_parity_err[n]) m_par[n] = 1'b1;
          if (mq[n].size() < DEPTH) mq[n].push_back(rx_byte[8*n +: 8]);
          else m_ovr[n] = 1'b1;
        end
      end
      tick();
    end
    clr();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
